// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between two bus masters.
// Master 0 is the CPU and master 1 is a secondary master such as DMA or debug.
// The winning request is latched, and one valid/ready transaction is run on
// the memory port. A one-cycle ack then returns to the owning master.
// States: IDLE -> ACCESS -> RESP -> IDLE. Every output comes from a register.
// Optional macro ARB_RR_EN selects round-robin arbitration on ties.
// When it is undefined, master 0 wins every tie (fixed priority).
module mem_bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_valid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          grant_s;
  logic          capture_s;
  logic          winner_s;
  logic [DW-1:0] rdata_r;

  // Pick the master that would win if an arbitration happened this cycle.
  always_comb begin
    winner_s = 1'b0;
`ifdef ARB_RR_EN
    if (m0_req && m1_req) begin
      winner_s = ~owner;
    end else if (m0_req) begin
      winner_s = 1'b0;
    end else begin
      winner_s = 1'b1;
    end
`else
    if (m0_req) begin
      winner_s = 1'b0;
    end else begin
      winner_s = 1'b1;
    end
`endif
  end

  // Compute the next state, the grant strobe and the read-data capture strobe.
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_nxt_s = ACCESS;
          grant_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_nxt_s = RESP;
          capture_s   = ~mem_we;
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      RESP: begin
        // Always pass through IDLE, so a master that drops req after its ack is never granted again.
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Register the state-decoded control outputs one edge early, so they line up with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid <= 1'b0;
      busy      <= 1'b0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
    end else begin
      mem_valid <= (state_nxt_s == ACCESS);
      busy      <= (state_nxt_s != IDLE);
      // owner is already stable by the time ACCESS moves to RESP.
      m0_ack    <= (state_nxt_s == RESP) && !owner;
      m1_ack    <= (state_nxt_s == RESP) && owner;
    end
  end

  // Latch the winner's request at the grant edge and hold it for the whole transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner     <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= {AW{1'b0}};
      mem_wdata <= {DW{1'b0}};
    end else if (grant_s) begin
      owner     <= winner_s;
      mem_we    <= winner_s ? m1_we    : m0_we;
      mem_addr  <= winner_s ? m1_addr  : m0_addr;
      mem_wdata <= winner_s ? m1_wdata : m0_wdata;
    end
  end

  // Shared read-data register. It is loaded only when a read completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_r <= {DW{1'b0}};
    end else if (capture_s) begin
      rdata_r <= mem_rdata;
    end
  end

  assign m0_rdata = rdata_r;
  assign m1_rdata = rdata_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter.
// Inputs are driven on the falling edge, and outputs are sampled there too.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m0_ack;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_ack;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        mem_valid, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, owner;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic exp_own [4];

  mem_bus_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef ARB_RR_EN
    exp_own[0] = 1'b0; exp_own[1] = 1'b1; exp_own[2] = 1'b0; exp_own[3] = 1'b1;
`else
    exp_own[0] = 1'b0; exp_own[1] = 1'b0; exp_own[2] = 1'b0; exp_own[3] = 1'b0;
`endif
    reset = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;

    // Reset state
    tick();
    chk_vec("rst_valid", mem_valid, 32'd0);
    chk_vec("rst_busy",  busy,      32'd0);
    chk_vec("rst_owner", owner,     32'd1);
    chk_vec("rst_ack0",  m0_ack,    32'd0);
    chk_vec("rst_ack1",  m1_ack,    32'd0);
    chk_vec("rst_addr",  mem_addr,  32'h0);
    chk_vec("rst_rdata", m0_rdata,  32'h0);
    reset = 1'b0;
    tick();

    // Single read, no wait states
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    chk_vec("rd_valid", mem_valid, 32'd1);
    chk_vec("rd_addr",  mem_addr,  32'h10);
    chk_vec("rd_we",    mem_we,    32'd0);
    chk_vec("rd_busy",  busy,      32'd1);
    chk_vec("rd_owner", owner,     32'd0);
    chk_vec("rd_ack0_early", m0_ack, 32'd0);
    tick();
    chk_vec("rd_valid_off", mem_valid, 32'd0);
    chk_vec("rd_ack0",  m0_ack,   32'd1);
    chk_vec("rd_ack1",  m1_ack,   32'd0);
    chk_vec("rd_rdata", m0_rdata, 32'hDEADBEEF);
    chk_vec("rd_busy2", busy,     32'd1);
    m0_req = 1'b0; mem_ready = 1'b0;
    tick();
    chk_vec("rd_idle_busy", busy,   32'd0);
    chk_vec("rd_ack0_off",  m0_ack, 32'd0);

    // Write with three wait states; mem_rdata changes but must not be captured
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
    mem_rdata = 32'hBAD0BAD0;
    tick();
    m1_addr = 32'h77; m1_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      chk_vec("wr_valid", mem_valid, 32'd1);
      chk_vec("wr_addr",  mem_addr,  32'h20);
      chk_vec("wr_wdata", mem_wdata, 32'h12345678);
      chk_vec("wr_we",    mem_we,    32'd1);
      chk_vec("wr_ack1_early", m1_ack, 32'd0);
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    chk_vec("wr_valid_off", mem_valid, 32'd0);
    chk_vec("wr_ack1",  m1_ack,   32'd1);
    chk_vec("wr_ack0",  m0_ack,   32'd0);
    chk_vec("wr_owner", owner,    32'd1);
    chk_vec("wr_rdata", m1_rdata, 32'hDEADBEEF);
    m1_req = 1'b0; m1_we = 1'b0; mem_ready = 1'b0;
    tick();
    chk_vec("wr_ack1_off", m1_ack, 32'd0);

    // Request withdrawal and address change after the grant
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
    tick();
    chk_vec("wd_addr", mem_addr, 32'h40);
    m0_req = 1'b0; m0_addr = 32'h99;
    tick();
    chk_vec("wd_valid", mem_valid, 32'd1);
    chk_vec("wd_addr2", mem_addr,  32'h40);
    mem_ready = 1'b1; mem_rdata = 32'h000000A5;
    tick();
    chk_vec("wd_ack0",  m0_ack,   32'd1);
    chk_vec("wd_rdata", m0_rdata, 32'h000000A5);
    mem_ready = 1'b0;
    tick();
    chk_vec("wd_ack0_off", m0_ack, 32'd0);
    tick();
    chk_vec("wd_no_regrant", mem_valid, 32'd0);
    chk_vec("wd_idle_busy",  busy,      32'd0);

    // Back-to-back: m0 keeps requesting, so a grant comes every third cycle
    m0_req = 1'b1; m0_addr = 32'h80; mem_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk_vec("b2b_valid", mem_valid, (c % 3 == 0) ? 32'd1 : 32'd0);
      chk_vec("b2b_ack0",  m0_ack,    (c % 3 == 1) ? 32'd1 : 32'd0);
      if (c == 4) m0_req = 1'b0;
    end
    tick();
    chk_vec("b2b_no_dup", mem_valid, 32'd0);
    mem_ready = 1'b0;

    // Reset arrives asynchronously in the middle of ACCESS
    m0_req = 1'b1; m0_addr = 32'h50;
    tick();
    chk_vec("ra_valid_pre", mem_valid, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk_vec("ra_valid_async", mem_valid, 32'd0);
    chk_vec("ra_busy_async",  busy,      32'd0);
    chk_vec("ra_owner",       owner,     32'd1);
    chk_vec("ra_rdata",       m0_rdata,  32'h0);
    m0_req = 1'b0;
    tick();
    reset = 1'b0; mem_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk_vec("ra_no_ack0",  m0_ack,    32'd0);
      chk_vec("ra_no_valid", mem_valid, 32'd0);
    end
    mem_ready = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h60;
    tick();
    chk_vec("ra_fresh_valid", mem_valid, 32'd1);
    chk_vec("ra_fresh_addr",  mem_addr,  32'h60);
    chk_vec("ra_fresh_owner", owner,     32'd1);
    mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    chk_vec("ra_fresh_ack1", m1_ack,   32'd1);
    chk_vec("ra_fresh_rd",   m1_rdata, 32'hCAFEF00D);
    m1_req = 1'b0;
    tick();

    // Contention: both requests high; each master drops req in its ack cycle and raises it again one cycle later
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h200;
    for (int g = 0; g < 4; g++) begin
      tick();
      chk_vec("ct_valid", mem_valid, 32'd1);
      chk_vec("ct_owner", owner,     {31'd0, exp_own[g]});
      chk_vec("ct_addr",  mem_addr,  exp_own[g] ? 32'h200 : 32'h100);
      tick();
      chk_vec("ct_ack0", m0_ack, {31'd0, ~exp_own[g]});
      chk_vec("ct_ack1", m1_ack, {31'd0, exp_own[g]});
      if (exp_own[g]) m1_req = 1'b0; else m0_req = 1'b0;
      tick();
      m0_req = 1'b1; m1_req = 1'b1;
    end
    m0_req = 1'b0;
    tick();
    chk_vec("ct_m1_owner", owner,    32'd1);
    chk_vec("ct_m1_addr",  mem_addr, 32'h200);
    tick();
    chk_vec("ct_m1_ack", m1_ack, 32'd1);
    m1_req = 1'b0; mem_ready = 1'b0;
    tick();
    chk_vec("ct_end_busy", busy, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, single-slave arbiter that shares the single unified memory port of the multicycle core between the CPU (master 0) and a secondary master such as DMA or debug (master 1).
- Latches the winning master's request and drives one memory transaction with a valid/ready handshake.
- Returns read data and a one-cycle ack to the owning master.
- Sits between the core and its bus masters on one side and the memory on the other.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m0_req  in  1  master 0 request; held until m0_ack.
- m0_we  in  1  master 0 write enable (1 = write, 0 = read).
- m0_addr  in  AW  master 0 address.
- m0_wdata  in  DW  master 0 write data.
- m0_ack  out  1  master 0 transaction complete; one-cycle pulse.
- m0_rdata  out  DW  master 0 read data; valid while m0_ack=1.
- m1_req, m1_we, m1_addr, m1_wdata  in  1/1/AW/DW  master 1 request set, same meaning as master 0.
- m1_ack, m1_rdata  out  1/DW  master 1 response set, same meaning as master 0.
- mem_valid  out  1  request valid to memory.
- mem_we  out  1  write enable to memory.
- mem_addr  out  AW  address to memory.
- mem_wdata  out  DW  write data to memory.
- mem_ready  in  1  memory completes the transaction at this edge.
- mem_rdata  in  DW  memory read data; sampled when mem_valid & mem_ready.
- busy  out  1  1 in any state other than IDLE.
- owner  out  1  index of the current or last granted master.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - m0_ack=m1_ack=0; rdata register=0; busy=0; owner=1, so master 0 wins the first tie.
- FSM states: IDLE, ACCESS, RESP. All outputs are registered or decoded from state only. No combinational path from any input to any output.
- IDLE:
  - If m0_req|m1_req at a clock edge, select the winner (see arbitration).
  - At that edge, latch the winner's we/addr/wdata into the mem_* registers, set owner=winner, and go to ACCESS.
  - With no request, remain in IDLE.
- ACCESS:
  - mem_valid=1; mem_we/mem_addr/mem_wdata stay stable for the whole state.
  - On an edge with mem_ready=1:
    - For a read, capture mem_rdata into the rdata register; for a write, leave rdata unchanged.
    - Go to RESP.
  - With mem_ready=0, stay in ACCESS indefinitely, adding wait states.
- RESP:
  - mem_valid=0; ack of the owner=1 for exactly this one cycle; the other ack=0.
  - Next edge goes unconditionally to IDLE.
- m0_rdata and m1_rdata are both driven from the shared rdata register. Each is meaningful only with its own ack.
- Latency with zero wait states: request seen at edge E0 → mem_valid during E0..E1 → ack during E1..E2 → IDLE at E2.
  - Maximum throughput is one transaction per 3 cycles.
  - The IDLE cycle after RESP guarantees that a master dropping req on the edge after ack is never re-granted.
- Boundary conditions:
  - A master dropping req during ACCESS does not abort the transaction; it completes and ack is still pulsed.
  - Changes on m*_addr/we/wdata after the grant edge are ignored.
  - A losing master's req stays pending and is considered at the next IDLE arbitration.
  - Both reqs with either ack pending: the current transaction is never preempted.
  - Reset in ACCESS or RESP: mem_valid and ack drop immediately. The transaction is lost, with no ack after reset.
  - mem_ready while not in ACCESS is ignored.

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: round-robin arbitration. On simultaneous requests the master that is not `owner` wins; with a single request that master wins. owner updates on each grant.
- Undefined: fixed priority, master 0 always wins ties. owner still reports the granted master for observation.

Test Plan:
- Single read, no wait:
  - Stimulus: m0_req=1, m0_we=0, m0_addr=0x00000010; mem_ready=1 when mem_valid, with mem_rdata=0xDEADBEEF.
  - Required response: mem_valid for 1 cycle with mem_addr=0x10; m0_ack one cycle later with m0_rdata=0xDEADBEEF; m1_ack stays 0; busy high for 2 cycles.
- Write with waits:
  - Stimulus: m1_req=1, m1_we=1, addr=0x20, wdata=0x12345678; mem_ready held low 3 cycles.
  - Required response: mem_valid high 4 cycles with stable mem_addr=0x20 and mem_wdata=0x12345678; m1_ack one pulse; rdata register unchanged.
- Contention:
  - Stimulus: both reqs high continuously, each dropped one cycle after its ack, then re-raised.
  - Required response, with ARB_RR_EN: grants alternate m0,m1,m0,m1.
  - Required response, without ARB_RR_EN: m0 wins every tie, and m1 is granted only while m0_req=0.
- Request withdrawal:
  - Stimulus: m0_req dropped in ACCESS; m0_addr changed to 0x99 after the grant edge.
  - Required response: the transaction completes at the original address; m0_ack still pulses once.
- Reset mid-access:
  - Stimulus: assert reset asynchronously while in ACCESS with mem_ready=0.
  - Required response: mem_valid=0 and busy=0 immediately without waiting for a clock edge; no ack after release; the next request starts fresh from IDLE.
- Back-to-back spacing:
  - Stimulus: m0 re-raises req on the edge after its ack.
  - Required response: the second mem_valid rises exactly 3 cycles after the first, with no duplicate grant.
